// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit alu datapath.
// Owns the accumulator, carry flag, program counter and an 8-entry register file.
module alu_seq_ctrl #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_re,
    input  logic [11:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [3:0]      alu_op,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic            alu_ci,
    input  logic [7:0]      alu_out,
    input  logic            alu_cy,
    output logic [7:0]      acc,
    output logic            cy,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_ADC  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_SBB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_STA  = 4'hA;
    localparam logic [3:0] OP_LDA  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_SETC = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_NOT  = 4'b0101;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    state_t          state, state_nxt;
    logic [11:0]     ir;
    logic [7:0]      rf [8];
    logic [3:0]      opc;
    logic [7:0]      field;
    logic [2:0]      rn;
    logic [7:0]      rn_val;
    logic [7:0]      acc_nxt;
    logic            cy_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            rf_we;

    // Jump targets come from the 8-bit field, resized to the pc width.
    function automatic logic [PC_W-1:0] to_pc(input logic [7:0] f);
        return PC_W'(f);
    endfunction

    assign opc    = ir[11:8];
    assign field  = ir[7:0];
    assign rn     = field[2:0];
    assign rn_val = rf[rn];

    assign imem_addr = pc;
    assign imem_re   = (state == S_FETCH);
    assign busy      = (state == S_FETCH) || (state == S_EXEC);
    assign halted    = (state == S_HALT);
    assign alu_a     = acc;

    // ALU drive: idle pattern everywhere except EXEC of an ALU-using opcode.
    always_comb begin
        alu_op = ALU_PASS;
        alu_b  = 8'h00;
        alu_ci = 1'b0;
        if (state == S_EXEC) begin
            case (opc)
                OP_LDI: alu_b = field;
                OP_ADD: begin
                    alu_op = ALU_ADD;
                    alu_b  = rn_val;
                end
                OP_ADC: begin
                    alu_op = ALU_ADD;
                    alu_b  = rn_val;
                    alu_ci = cy;
                end
                OP_SUB: begin
                    alu_op = ALU_SUB;
                    alu_b  = rn_val;
                end
                OP_SBB: begin
                    alu_op = ALU_SUB;
                    alu_b  = rn_val;
                    alu_ci = cy;
                end
                OP_AND: begin
                    alu_op = ALU_AND;
                    alu_b  = rn_val;
                end
                OP_OR: begin
                    alu_op = ALU_OR;
                    alu_b  = rn_val;
                end
                OP_XOR: begin
                    alu_op = ALU_XOR;
                    alu_b  = rn_val;
                end
                OP_NOT: alu_op = ALU_NOT;
                OP_LDA: alu_b = rn_val;
                default: ;
            endcase
        end
    end

    // Next state and writeback values; writeback only commits at the end of EXEC.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cy_nxt    = cy;
        pc_nxt    = pc;
        rf_we     = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_valid) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                pc_nxt    = pc + PC_W'(1);
                case (opc)
                    OP_LDI, OP_SUB, OP_SBB, OP_AND, OP_OR,
                    OP_XOR, OP_NOT, OP_LDA: acc_nxt = alu_out;
                    OP_ADD, OP_ADC: begin
                        acc_nxt = alu_out;
                        cy_nxt  = alu_cy;
                    end
                    OP_STA:  rf_we = 1'b1;
                    OP_JMP:  pc_nxt = to_pc(field);
                    OP_JC: begin
                        if (cy) pc_nxt = to_pc(field);
                    end
                    OP_SETC: cy_nxt = field[0];
                    OP_HLT:  state_nxt = S_HALT;
                    default: ;
                endcase
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= PC_W'(RESET_PC);
            acc   <= 8'h00;
            cy    <= 1'b0;
            ir    <= 12'h000;
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            acc   <= acc_nxt;
            cy    <= cy_nxt;
            if (state == S_FETCH && imem_valid) ir <= imem_rdata;
            if (rf_we) rf[rn] <= acc;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: the stimulus acts as program memory and queues the
// expected post-instruction state; a monitor checks each executed instruction.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  imem_addr;
    logic        imem_re;
    logic [11:0] imem_rdata;
    logic        imem_valid;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_ci;
    logic [7:0]  alu_out;
    logic        alu_cy;
    logic [7:0]  acc;
    logic        cy;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;

    typedef struct {
        logic [3:0] op;
        logic [7:0] b;
        logic       ci;
        logic [7:0] acc;
        logic       cy;
        logic [7:0] pc;
        logic       halt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic in_exec;
    logic [8:0] alu_t;

    alu_seq_ctrl #(.PC_W(8), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_re(imem_re),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
        .alu_out(alu_out), .alu_cy(alu_cy),
        .acc(acc), .cy(cy), .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    // Reference model of the external 8-bit alu.
    always_comb begin
        alu_t   = 9'h000;
        alu_out = 8'h00;
        alu_cy  = 1'b0;
        case (alu_op)
            4'h0: begin
                alu_t   = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ci};
                alu_out = alu_t[7:0];
                alu_cy  = alu_t[8];
            end
            4'h1: begin
                alu_t   = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_ci};
                alu_out = alu_t[7:0];
                alu_cy  = alu_t[8];
            end
            4'h2: alu_out = alu_a & alu_b;
            4'h3: alu_out = alu_a | alu_b;
            4'h4: alu_out = alu_a ^ alu_b;
            4'h5: alu_out = ~alu_a;
            default: alu_out = alu_b;
        endcase
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endfunction

    function automatic exp_t mk(input logic [3:0] op, input logic [7:0] b, input logic ci,
                                input logic [7:0] a, input logic c, input logic [7:0] p,
                                input logic h);
        exp_t e;
        e.op = op; e.b = b; e.ci = ci; e.acc = a; e.cy = c; e.pc = p; e.halt = h;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_exec <= 1'b0;
        else        in_exec <= imem_re && imem_valid;
    end

    // Monitor: checks ALU drive mid-EXEC, then architectural state after writeback.
    initial begin
        forever begin
            @(negedge clk);
            if (in_exec) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_exec: got exec at pc %0h, expected none", pc);
                end else begin
                    mon_e = sb.pop_front();
                    check("alu_op", alu_op, mon_e.op);
                    check("alu_b", alu_b, mon_e.b);
                    check("alu_ci", alu_ci, mon_e.ci);
                    @(posedge clk);
                    #1;
                    check("acc", acc, mon_e.acc);
                    check("cy", cy, mon_e.cy);
                    check("pc", pc, mon_e.pc);
                    check("halted", halted, mon_e.halt);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [11:0] ins, input logic [7:0] addr, input int dly,
                         input bit b2b, input exp_t e);
        int k = 0;
        while (!imem_re && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("fetch_req", imem_re, 1);
        if (b2b) check("latency", k, 1);
        check("imem_addr", imem_addr, addr);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check("stall_re", imem_re, 1);
            check("stall_addr", imem_addr, addr);
            check("stall_pc", pc, addr);
            check("stall_busy", busy, 1);
        end
        sb.push_back(e);
        imem_rdata = ins;
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 12'h000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 12'h000;
        repeat (2) @(negedge clk);
        check("rst_acc", acc, 8'h00);
        check("rst_cy", cy, 0);
        check("rst_pc", pc, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_re", imem_re, 0);
        check("rst_alu_op", alu_op, 4'hF);
        check("rst_alu_b", alu_b, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Basic program ending in HLT
        pulse_start();
        issue(12'h105, 8'h00, 0, 0, mk(4'hF, 8'h05, 0, 8'h05, 0, 8'h01, 0));
        issue(12'hA01, 8'h01, 0, 1, mk(4'hF, 8'h00, 0, 8'h05, 0, 8'h02, 0));
        issue(12'h1FE, 8'h02, 0, 1, mk(4'hF, 8'hFE, 0, 8'hFE, 0, 8'h03, 0));
        issue(12'h201, 8'h03, 0, 1, mk(4'h0, 8'h05, 0, 8'h03, 1, 8'h04, 0));
        issue(12'hF00, 8'h04, 0, 1, mk(4'hF, 8'h00, 0, 8'h03, 1, 8'h05, 1));
        imem_rdata = 12'h1AA;
        imem_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("halt_state", halted, 1);
            check("halt_busy", busy, 0);
            check("halt_re", imem_re, 0);
            check("halt_pc", pc, 8'h05);
        end
        imem_valid = 1'b0;
        imem_rdata = 12'h000;

        // Resume after HLT: carry chain, stalled fetch, logic ops
        pulse_start();
        issue(12'h301, 8'h05, 0, 0, mk(4'h0, 8'h05, 1, 8'h09, 0, 8'h06, 0));
        issue(12'hE01, 8'h06, 0, 1, mk(4'hF, 8'h00, 0, 8'h09, 1, 8'h07, 0));
        issue(12'h501, 8'h07, 0, 1, mk(4'h1, 8'h05, 1, 8'h03, 1, 8'h08, 0));
        issue(12'hB01, 8'h08, 0, 1, mk(4'hF, 8'h05, 0, 8'h05, 1, 8'h09, 0));
        issue(12'h1F0, 8'h09, 4, 1, mk(4'hF, 8'hF0, 0, 8'hF0, 1, 8'h0A, 0));
        issue(12'h13C, 8'h0A, 0, 1, mk(4'hF, 8'h3C, 0, 8'h3C, 1, 8'h0B, 0));
        issue(12'hA02, 8'h0B, 0, 1, mk(4'hF, 8'h00, 0, 8'h3C, 1, 8'h0C, 0));
        issue(12'h1F0, 8'h0C, 0, 1, mk(4'hF, 8'hF0, 0, 8'hF0, 1, 8'h0D, 0));
        issue(12'h6FA, 8'h0D, 0, 1, mk(4'h2, 8'h3C, 0, 8'h30, 1, 8'h0E, 0));
        issue(12'h1F0, 8'h0E, 0, 1, mk(4'hF, 8'hF0, 0, 8'hF0, 1, 8'h0F, 0));
        issue(12'h702, 8'h0F, 0, 1, mk(4'h3, 8'h3C, 0, 8'hFC, 1, 8'h10, 0));
        issue(12'h1F0, 8'h10, 0, 1, mk(4'hF, 8'hF0, 0, 8'hF0, 1, 8'h11, 0));
        issue(12'h802, 8'h11, 0, 1, mk(4'h4, 8'h3C, 0, 8'hCC, 1, 8'h12, 0));
        issue(12'h1F0, 8'h12, 0, 1, mk(4'hF, 8'hF0, 0, 8'hF0, 1, 8'h13, 0));
        issue(12'h900, 8'h13, 0, 1, mk(4'h5, 8'h00, 0, 8'h0F, 1, 8'h14, 0));

        // Branching and pc wrap
        issue(12'hE00, 8'h14, 0, 1, mk(4'hF, 8'h00, 0, 8'h0F, 0, 8'h15, 0));
        issue(12'hD10, 8'h15, 0, 1, mk(4'hF, 8'h00, 0, 8'h0F, 0, 8'h16, 0));
        issue(12'hE01, 8'h16, 0, 1, mk(4'hF, 8'h00, 0, 8'h0F, 1, 8'h17, 0));
        issue(12'hD10, 8'h17, 0, 1, mk(4'hF, 8'h00, 0, 8'h0F, 1, 8'h10, 0));
        issue(12'hCFF, 8'h10, 0, 1, mk(4'hF, 8'h00, 0, 8'h0F, 1, 8'hFF, 0));
        issue(12'hC00, 8'hFF, 0, 1, mk(4'hF, 8'h00, 0, 8'h0F, 1, 8'h00, 0));
        issue(12'hCFF, 8'h00, 0, 1, mk(4'hF, 8'h00, 0, 8'h0F, 1, 8'hFF, 0));
        issue(12'h000, 8'hFF, 0, 1, mk(4'hF, 8'h00, 0, 8'h0F, 1, 8'h00, 0));
        issue(12'h000, 8'h00, 0, 1, mk(4'hF, 8'h00, 0, 8'h0F, 1, 8'h01, 0));

        // Reset in the middle of an ADD
        @(negedge clk);
        check("abort_re", imem_re, 1);
        check("abort_addr", imem_addr, 8'h01);
        imem_rdata = 12'h201;
        imem_valid = 1'b1;
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        check("abort_alu_op", alu_op, 4'h0);
        check("abort_alu_b", alu_b, 8'h05);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_acc", acc, 8'h00);
        check("abort_cy", cy, 0);
        check("abort_pc", pc, 8'h00);
        check("abort_busy", busy, 0);
        check("abort_halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // start while busy is ignored; start from HALT resumes after HLT
        pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_busy", busy, 1);
        check("busy_start_addr", imem_addr, 8'h00);
        issue(12'h107, 8'h00, 0, 0, mk(4'hF, 8'h07, 0, 8'h07, 0, 8'h01, 0));
        issue(12'hF00, 8'h01, 0, 1, mk(4'hF, 8'h00, 0, 8'h07, 0, 8'h02, 1));
        pulse_start();
        issue(12'hB01, 8'h02, 0, 0, mk(4'hF, 8'h00, 0, 8'h00, 0, 8'h03, 0));

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
